// File: rtl/button_press_classifier_pkg.sv
// Shared types and default timing constants for the button classifier.
// Optional auto-repeat feature is enabled by BTN_CLASS_REPEAT_EN.
package btn_pkg;

  typedef enum logic [2:0] {
    IDLE,
    PRESSED,
    LONG_HELD,
    WAIT_SECOND,
    SECOND_PRESSED
  } btn_class_state_t;

  localparam int CLK_DIV_1KHZ  = 100_000;
  localparam int LONG_MS_DEF   = 1000;
  localparam int DOUBLE_MS_DEF = 300;
  localparam int REPEAT_MS_DEF = 200;

  function automatic int max3(
    input int a,
    input int b,
    input int c
  );
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/button_press_classifier_if.sv
// Edge inputs from the detector stage and classified
// event pulses towards the control FSMs.
interface button_press_classifier_if;

  logic rising_edge;
  logic falling_edge;
  logic short_press;
  logic long_press;
  logic double_click;
  logic busy;

  modport master (
    output rising_edge,
    output falling_edge,
    input  short_press,
    input  long_press,
    input  double_click,
    input  busy
  );

  modport slave (
    input  rising_edge,
    input  falling_edge,
    output short_press,
    output long_press,
    output double_click,
    output busy
  );

endinterface

// File: rtl/button_press_classifier_ms_tick_gen.sv
// Free-running divider producing a one-cycle tick
// every CLK_DIV clocks (1 kHz from 100 MHz by default).
module ms_tick_gen
  import btn_pkg::*;
#(
  parameter int CLK_DIV = CLK_DIV_1KHZ
) (
  input  logic clk,
  input  logic reset,
  output logic tick
);

  localparam int W =
    (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  assign tick  = (cnt_q == W'(CLK_DIV - 1));
  assign cnt_d = tick ? '0 : cnt_q + 1'b1;

  // Divider counter, wraps after CLK_DIV-1.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

endmodule

// File: rtl/button_press_classifier.sv
// Classifies debounced press/release edges into short press,
// long press and double click. BTN_CLASS_REPEAT_EN adds auto-repeat.
module button_press_classifier
  import btn_pkg::*;
#(
  parameter int CLK_DIV   = CLK_DIV_1KHZ,
  parameter int LONG_MS   = LONG_MS_DEF,
  parameter int DOUBLE_MS = DOUBLE_MS_DEF,
  parameter int REPEAT_MS = REPEAT_MS_DEF
) (
  input logic                      clk,
  input logic                      reset,
  button_press_classifier_if.slave bus
);

  localparam int MS_MAX =
    max3(LONG_MS, DOUBLE_MS, REPEAT_MS);
  localparam int MS_W = $clog2(MS_MAX + 1);

  btn_class_state_t state_q;
  logic [MS_W-1:0]  ms_cnt_q;
  logic [MS_W-1:0]  ms_cnt_d;
  logic             short_q;
  logic             long_q;
  logic             double_q;

  logic ms_tick;
  logic ms_sat;
  logic rise;
  logic fall;
  logic long_hit;
  logic dbl_hit;

  ms_tick_gen #(
    .CLK_DIV (CLK_DIV)
  ) u_tick (
    .clk   (clk),
    .reset (reset),
    .tick  (ms_tick)
  );

  // Coincident edges carry no usable information.
  assign rise = bus.rising_edge & ~bus.falling_edge;
  assign fall = bus.falling_edge & ~bus.rising_edge;

  assign ms_sat   = (ms_cnt_q == {MS_W{1'b1}});
  assign ms_cnt_d = (ms_tick && !ms_sat) ?
                    ms_cnt_q + 1'b1 : ms_cnt_q;

  assign long_hit = ms_tick &&
    (ms_cnt_q == MS_W'(LONG_MS - 1));
  assign dbl_hit  = ms_tick &&
    (ms_cnt_q == MS_W'(DOUBLE_MS - 1));

`ifdef BTN_CLASS_REPEAT_EN
  logic rep_hit;
  assign rep_hit = ms_tick &&
    (ms_cnt_q == MS_W'(REPEAT_MS - 1));
`endif

  // Gesture FSM with ms counter and registered pulses.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      ms_cnt_q <= '0;
      short_q  <= 1'b0;
      long_q   <= 1'b0;
      double_q <= 1'b0;
    end else begin
      short_q  <= 1'b0;
      long_q   <= 1'b0;
      double_q <= 1'b0;
      ms_cnt_q <= ms_cnt_d;
      unique case (state_q)
        IDLE: begin
          if (rise) begin
            state_q  <= PRESSED;
            ms_cnt_q <= '0;
          end
        end
        PRESSED: begin
          if (fall) begin
            state_q  <= WAIT_SECOND;
            ms_cnt_q <= '0;
          end else if (long_hit) begin
            state_q  <= LONG_HELD;
            ms_cnt_q <= '0;
            long_q   <= 1'b1;
          end
        end
        LONG_HELD: begin
          if (fall) begin
            state_q  <= IDLE;
            ms_cnt_q <= '0;
          end
`ifdef BTN_CLASS_REPEAT_EN
          else if (rep_hit) begin
            ms_cnt_q <= '0;
            long_q   <= 1'b1;
          end
`endif
        end
        WAIT_SECOND: begin
          if (rise) begin
            state_q  <= SECOND_PRESSED;
            ms_cnt_q <= '0;
          end else if (dbl_hit) begin
            state_q  <= IDLE;
            ms_cnt_q <= '0;
            short_q  <= 1'b1;
          end
        end
        SECOND_PRESSED: begin
          if (fall) begin
            state_q  <= IDLE;
            ms_cnt_q <= '0;
            double_q <= 1'b1;
          end
        end
        default: begin
          state_q  <= IDLE;
          ms_cnt_q <= '0;
        end
      endcase
    end
  end

  assign bus.short_press  = short_q;
  assign bus.long_press   = long_q;
  assign bus.double_click = double_q;
  assign bus.busy         = (state_q != IDLE);

endmodule
